// File: rtl/sr_sched_pkg.sv
// Shared types and op encodings for the SR flag scheduler.
package sr_sched_pkg;

    localparam int unsigned OPW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRIVE = 2'd2,
        ACK   = 2'd3
    } state_e;

    localparam logic [OPW-1:0] OP_CLR  = 2'b00;
    localparam logic [OPW-1:0] OP_SET  = 2'b01;
    localparam logic [OPW-1:0] OP_TGL  = 2'b10;
    localparam logic [OPW-1:0] OP_HOLD = 2'b11;

    // Maps an op and the cell's current state to {s, r}; never returns 2'b11.
    function automatic logic [1:0] sr_decode(input logic [OPW-1:0] op,
                                             input logic q,
                                             input logic qn,
                                             input logic tgl_en);
        logic [1:0] sr;
        sr = 2'b00;
        case (op)
            OP_SET:  sr = 2'b10;
            OP_CLR:  sr = 2'b01;
            OP_TGL:  sr = tgl_en ? {qn, q} : 2'b00;
            default: sr = 2'b00;
        endcase
        return sr;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// Single SR flag flop with synchronous active-low reset; s=r=1 is never driven by its owner.
module sr_cell
    import sr_sched_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_s,
    input  logic i_r,
    output logic o_q,
    output logic o_qn
);

    logic r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_q <= 1'b0;
        end else begin
            case ({i_s, i_r})
                2'b10:   r_q <= 1'b1;
                2'b01:   r_q <= 1'b0;
                2'b11:   r_q <= 1'bx;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q  = r_q;
    assign o_qn = ~r_q;

endmodule

// File: rtl/sr_flag_sched.sv
// Round-robin scheduler turning granted requests into single S/R pulses on a flag bank.
// Build option: define SR_SCHED_TOGGLE_EN to make op 10 toggle; otherwise it acts as hold.
module sr_flag_sched
    import sr_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NFLAG = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NREQ-1:0]                  i_req,
    input  logic [2*NREQ-1:0]                i_op,
    input  logic [$clog2(NFLAG)*NREQ-1:0]    i_idx,
    output logic [NREQ-1:0]                  o_gnt,
    output logic [NREQ-1:0]                  o_done,
    output logic [NFLAG-1:0]                 o_flags,
    output logic                             o_busy
);

    localparam int unsigned IDXW = $clog2(NFLAG);
    localparam int unsigned REQW = $clog2(NREQ);

`ifdef SR_SCHED_TOGGLE_EN
    localparam logic TGL_EN = 1'b1;
`else
    localparam logic TGL_EN = 1'b0;
`endif

    state_e            r_state;
    state_e            w_state_nxt;

    logic [REQW-1:0]   r_ptr;
    logic [REQW-1:0]   r_win;
    logic [REQW-1:0]   w_win;
    logic [REQW-1:0]   w_cand;
    logic              w_found;
    logic              w_accept;

    logic [OPW-1:0]    r_op;
    logic [IDXW-1:0]   r_idx;

    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [NREQ-1:0]   w_done_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    logic [NFLAG-1:0]  r_s;
    logic [NFLAG-1:0]  r_r;
    logic [NFLAG-1:0]  w_s_nxt;
    logic [NFLAG-1:0]  w_r_nxt;
    logic [NFLAG-1:0]  w_q;
    logic [NFLAG-1:0]  w_qn;

    logic [OPW-1:0]    w_op_arr  [NREQ];
    logic [IDXW-1:0]   w_idx_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign w_op_arr[g]  = i_op[OPW*g +: OPW];
        assign w_idx_arr[g] = i_idx[IDXW*g +: IDXW];
    end

    // Round-robin pick: first requester at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_cand = REQW'((int'(r_ptr) + k) % int'(NREQ));
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_found;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_nxt = GRANT;
            GRANT:   w_state_nxt = DRIVE;
            DRIVE:   w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and of the cell drive; out-of-range idx matches no cell.
    always_comb begin
        w_gnt_nxt  = '0;
        w_done_nxt = '0;
        w_s_nxt    = '0;
        w_r_nxt    = '0;
        w_busy_nxt = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                if (w_found) w_gnt_nxt[w_win] = 1'b1;
            end
            GRANT: begin
                for (int f = 0; f < int'(NFLAG); f++) begin
                    if (r_idx == IDXW'(f)) begin
                        {w_s_nxt[f], w_r_nxt[f]} = sr_decode(r_op, w_q[f], w_qn[f], TGL_EN);
                    end
                end
            end
            DRIVE: begin
                w_done_nxt[r_win] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_gnt  <= '0;
            r_done <= '0;
            r_busy <= 1'b0;
            r_s    <= '0;
            r_r    <= '0;
            r_ptr  <= '0;
            r_win  <= '0;
            r_op   <= OP_HOLD;
            r_idx  <= '0;
        end else begin
            r_gnt  <= w_gnt_nxt;
            r_done <= w_done_nxt;
            r_busy <= w_busy_nxt;
            r_s    <= w_s_nxt;
            r_r    <= w_r_nxt;
            if (w_accept) begin
                r_win <= w_win;
                r_op  <= w_op_arr[w_win];
                r_idx <= w_idx_arr[w_win];
                r_ptr <= (w_win == REQW'(NREQ - 1)) ? '0 : w_win + REQW'(1);
            end
        end
    end

    for (genvar f = 0; f < NFLAG; f++) begin : g_cell
        sr_cell u_cell (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_s   (r_s[f]),
            .i_r   (r_r[f]),
            .o_q   (w_q[f]),
            .o_qn  (w_qn[f])
        );
    end

    assign o_gnt   = r_gnt;
    assign o_done  = r_done;
    assign o_busy  = r_busy;
    assign o_flags = w_q;

endmodule

// File: tb/tb_sr_flag_sched.sv
// Bench for sr_flag_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_sr_flag_sched;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 3;

`ifdef SR_SCHED_TOGGLE_EN
    localparam bit TGL = 1'b1;
`else
    localparam bit TGL = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [2*NREQ-1:0]      op;
    logic [IDXW*NREQ-1:0]   idx;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [NFLAG-1:0]       flags;
    logic                   busy;

    sr_flag_sched #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_op    (op),
        .i_idx   (idx),
        .o_gnt   (gnt),
        .o_done  (done),
        .o_flags (flags),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Model: an accepted op grants one cycle later, applies two cycles later, frees the slot after four.
    logic [NFLAG-1:0] m_flags;
    int               m_ptr;
    int               m_age;
    int               m_win;
    logic [1:0]       m_op;
    int               m_idx;
    logic [NREQ-1:0]  exp_gnt;
    logic [NREQ-1:0]  exp_done;
    logic             exp_busy;
    int               mode;
    int               gq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [1:0] o, input int x);
        req[i]             = 1'b1;
        op[2*i +: 2]       = o;
        idx[IDXW*i +: IDXW] = IDXW'(x);
    endtask

    task automatic model_edge();
        int c;
        if (!rst) begin
            m_flags  = '0;
            m_ptr    = 0;
            m_age    = 0;
            exp_gnt  = '0;
            exp_done = '0;
            exp_busy = 1'b0;
            return;
        end
        exp_gnt  = '0;
        exp_done = '0;
        if (m_age == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (req[c]) begin
                    m_win      = c;
                    m_op       = op[2*c +: 2];
                    m_idx      = int'(idx[IDXW*c +: IDXW]);
                    exp_gnt[c] = 1'b1;
                    m_ptr      = (c + 1) % NREQ;
                    m_age      = 1;
                    break;
                end
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (m_age == 2) begin
            if (m_idx < NFLAG) begin
                if (m_op == 2'b00) m_flags[m_idx] = 1'b0;
                else if (m_op == 2'b01) m_flags[m_idx] = 1'b1;
                else if (m_op == 2'b10 && TGL) m_flags[m_idx] = ~m_flags[m_idx];
            end
            exp_done[m_win] = 1'b1;
            m_age = 3;
        end else begin
            m_age = 0;
        end
        exp_busy = (m_age != 0);
    endtask

    // One clock: update requesters, predict the edge, compare on the following negedge.
    task automatic step();
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && exp_gnt[i] && mode != 2) req[i] = 1'b0;
        end
        if (mode == 1) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(99) < 30)
                    set_req(i, 2'($urandom_range(3)), int'($urandom_range(NFLAG - 1)));
                else if (req[i] && $urandom_range(39) == 0)
                    req[i] = 1'b0;
            end
        end
        model_edge();
        @(negedge clk);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("done", 32'(done), 32'(exp_done));
        check("busy", 32'(busy), 32'(exp_busy));
        check("flags", 32'(flags), 32'(m_flags));
        check("sr_excl", 32'(|(dut.r_s & dut.r_r)), 32'd0);
        if (gnt != '0) gq.push_back(oh_idx(gnt));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    function automatic int gq_at(input int k);
        return (gq.size() > k) ? gq[k] : -1;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_flags  = '0;
        m_ptr    = 0;
        m_age    = 0;
        m_win    = 0;
        m_op     = 2'b11;
        m_idx    = 0;
        exp_gnt  = '0;
        exp_done = '0;
        exp_busy = 1'b0;
        mode     = 0;
        rst      = 1'b0;
        req      = '1;
        op       = '0;
        idx      = '0;
        @(negedge clk);

        // reset with all requests pending
        run(2);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        req = '0;
        rst = 1'b1;

        // single op
        gq.delete();
        set_req(2, 2'b01, 5);
        run(4);
        check("single_flags", 32'(flags), 32'h20);
        check("single_gnt", 32'(gq_at(0)), 32'd2);

        // contention from reset
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        gq.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, i);
        run(16);
        check("contend_flags", 32'(flags), 32'h0F);
        for (int k = 0; k < 4; k++) check("contend_order", 32'(gq_at(k)), 32'(k));

        // fairness with two held requests
        mode = 2;
        gq.delete();
        req = '0;
        set_req(0, 2'b11, 0);
        set_req(1, 2'b11, 1);
        run(16);
        req  = '0;
        mode = 0;
        for (int k = 0; k < 4; k++) check("fair_order", 32'(gq_at(k)), 32'(k % 2));

        // reset while the op is being driven
        set_req(2, 2'b01, 6);
        run(2);
        rst = 1'b0;
        run(1);
        check("midrst_flags", 32'(flags), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b1;

        // conflicting set/clear on the same flag
        gq.delete();
        req = '0;
        set_req(0, 2'b01, 3);
        set_req(1, 2'b00, 3);
        run(4);
        check("conflict_first", 32'(flags[3]), 32'd1);
        run(8);
        check("conflict_last", 32'(flags[3]), 32'd0);
        check("conflict_gnt0", 32'(gq_at(0)), 32'd0);
        check("conflict_gnt1", 32'(gq_at(1)), 32'd1);

        // toggle
        set_req(0, 2'b01, 7);
        run(4);
        check("toggle_pre", 32'(flags[7]), 32'd1);
        set_req(0, 2'b10, 7);
        run(4);
        check("toggle_post", 32'(flags[7]), TGL ? 32'd0 : 32'd1);

        // random traffic with occasional resets
        mode = 1;
        repeat (3000) begin
            rst = ($urandom_range(199) != 0);
            step();
        end
        mode = 0;
        rst  = 1'b1;
        req  = '0;
        run(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
